// File: rtl/deconv2d_mc.sv
// deconv2d_mc: multi-channel, runtime-stride 2D transposed convolution.
// Build option SATURATE_OUT_EN clamps rd_data to PIXEL_BITS signed.
module deconv2d_mc #(
  parameter int IN_DIM     = 2,
  parameter int K          = 3,
  parameter int C_IN       = 2,
  parameter int PIXEL_BITS = 8,
  parameter int ACC_BITS   = 2*PIXEL_BITS+$clog2(C_IN*K*K)+1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [$clog2(K+1)-1:0]               stride,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic [PIXEL_BITS-1:0]                w_data,
  input  logic                                 pix_valid,
  output logic                                 pix_ready,
  input  logic [PIXEL_BITS-1:0]                pix_data,
  input  logic [$clog2(IN_DIM*K*IN_DIM*K)-1:0] rd_addr,
`ifdef SATURATE_OUT_EN
  output logic [PIXEL_BITS-1:0]                rd_data,
`else
  output logic [ACC_BITS-1:0]                  rd_data,
`endif
  output logic [$clog2(IN_DIM*K+1)-1:0]        out_dim,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 cfg_err
);
  localparam int OUT_MAX = IN_DIM*K;
  localparam int NACC = OUT_MAX*OUT_MAX;
  localparam int NW = C_IN*K*K;
  localparam int AW = $clog2(NACC);
  localparam int SW = $clog2(K+1);
  localparam int ODW = $clog2(OUT_MAX+1);
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam int DW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int PB = PIXEL_BITS;
  localparam logic [WW-1:0] W_LAST = WW'(NW-1);
  localparam logic [CW-1:0] C_LAST = CW'(C_IN-1);
  localparam logic [DW-1:0] D_LAST = DW'(IN_DIM-1);
  localparam logic [KW-1:0] K_LAST = KW'(K-1);
`ifdef SATURATE_OUT_EN
  localparam logic signed [ACC_BITS-1:0] SAT_HI =
    ACC_BITS'((1 << (PB-1)) - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_LO =
    ACC_BITS'(-(1 << (PB-1)));
`endif

  typedef enum logic [2:0] {
    IDLE, LOAD_W, WAIT_PIX, MAC, DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [PB-1:0]       w_q [NW];
  logic signed [ACC_BITS-1:0] acc_q [NACC];
  logic signed [PB-1:0]       pix_q;
  logic [WW-1:0]              wcnt_q;
  logic [CW-1:0]              c_q;
  logic [DW-1:0]              py_q, px_q;
  logic [KW-1:0]              ky_q, kx_q;
  logic [SW-1:0]              s_q;
  logic [ODW-1:0]             od_q;
  logic                       cfg_err_q;
  logic [$bits(rd_data)-1:0]  rd_q, rd_d;

  logic                       start_ok, w_hs, p_hs;
  logic                       k_last, last_pix;
  int                         row_i, col_i;
  int                         rd_row, rd_col;
  logic                       rd_hit;
  logic [AW-1:0]              mac_addr, rd_idx;
  logic [WW-1:0]              widx;
  logic signed [2*PB-1:0]     prod;
  logic signed [ACC_BITS-1:0] prod_ext, rd_val;

  // FSM next state and handshake/status outputs
  always_comb begin
    state_d   = state_q;
    w_ready   = 1'b0;
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    w_hs      = 1'b0;
    p_hs      = 1'b0;
    start_ok  = start && (stride != '0) && (int'(stride) <= K);
    k_last    = (ky_q == K_LAST) && (kx_q == K_LAST);
    last_pix  = (c_q == C_LAST) && (py_q == D_LAST) &&
                (px_q == D_LAST);
    unique case (state_q)
      IDLE: if (start_ok) state_d = LOAD_W;
      LOAD_W: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (w_valid) begin
          w_hs = 1'b1;
          if (wcnt_q == W_LAST) state_d = WAIT_PIX;
        end
      end
      WAIT_PIX: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (pix_valid) begin
          p_hs    = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        busy = 1'b1;
        if (k_last) state_d = last_pix ? DONE : WAIT_PIX;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scatter address, weight index and sign-extended product
  always_comb begin
    row_i    = int'(py_q) * int'(s_q) + int'(ky_q);
    col_i    = int'(px_q) * int'(s_q) + int'(kx_q);
    mac_addr = AW'(row_i * OUT_MAX + col_i);
    widx     = WW'((int'(c_q) * K + int'(ky_q)) * K + int'(kx_q));
    prod     = pix_q * w_q[widx];
    prod_ext = {{(ACC_BITS-2*PB){prod[2*PB-1]}}, prod};
  end

  // Read-port address decode and optional clamp
  always_comb begin
    rd_row = int'(rd_addr) / OUT_MAX;
    rd_col = int'(rd_addr) % OUT_MAX;
    rd_hit = (int'(rd_addr) < NACC) && (rd_row < int'(od_q)) &&
             (rd_col < int'(od_q));
    rd_idx = rd_hit ? rd_addr : '0;
    rd_val = rd_hit ? acc_q[rd_idx] : '0;
`ifdef SATURATE_OUT_EN
    if (rd_val > SAT_HI)      rd_d = SAT_HI[PB-1:0];
    else if (rd_val < SAT_LO) rd_d = SAT_LO[PB-1:0];
    else                      rd_d = rd_val[PB-1:0];
`else
    rd_d = rd_val;
`endif
  end

  // State, counters, config latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      c_q       <= '0;
      py_q      <= '0;
      px_q      <= '0;
      ky_q      <= '0;
      kx_q      <= '0;
      s_q       <= '0;
      od_q      <= '0;
      pix_q     <= '0;
      cfg_err_q <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= (state_q == IDLE) && start && !start_ok;
      rd_q      <= busy ? '0 : rd_d;
      if (state_q == IDLE && start_ok) begin
        s_q    <= stride;
        od_q   <= ODW'((IN_DIM-1) * int'(stride) + K);
        wcnt_q <= '0;
        c_q    <= '0;
        py_q   <= '0;
        px_q   <= '0;
      end
      if (w_hs) wcnt_q <= wcnt_q + WW'(1);
      if (p_hs) begin
        pix_q <= pix_data;
        ky_q  <= '0;
        kx_q  <= '0;
      end
      if (state_q == MAC) begin
        if (kx_q != K_LAST) begin
          kx_q <= kx_q + KW'(1);
        end else begin
          kx_q <= '0;
          if (ky_q != K_LAST) begin
            ky_q <= ky_q + KW'(1);
          end else begin
            ky_q <= '0;
            if (px_q != D_LAST) begin
              px_q <= px_q + DW'(1);
            end else begin
              px_q <= '0;
              if (py_q != D_LAST) begin
                py_q <= py_q + DW'(1);
              end else begin
                py_q <= '0;
                c_q  <= (c_q == C_LAST) ? '0 : c_q + CW'(1);
              end
            end
          end
        end
      end
    end
  end

  // Weight RAM: written in arrival order, retained between jobs
  always_ff @(posedge clk) begin
    if (w_hs) w_q[wcnt_q] <= w_data;
  end

  // Accumulator RAM: cleared on reset and job start, one MAC per cycle
  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start_ok)) begin
      for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
    end else if (state_q == MAC) begin
      acc_q[mac_addr] <= acc_q[mac_addr] + prod_ext;
    end
  end

  assign rd_data = rd_q;
  assign out_dim = od_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_deconv2d_mc.sv
// tb_deconv2d_mc: random and directed jobs against a gather-form
// reference of the transposed convolution.
module tb_deconv2d_mc;
  localparam int IN_DIM = 2;
  localparam int K = 3;
  localparam int C_IN = 2;
  localparam int PB = 8;
  localparam int ACC = 2*PB+$clog2(C_IN*K*K)+1;
  localparam int OM = IN_DIM*K;
  localparam int NW = C_IN*K*K;
  localparam int NP = C_IN*IN_DIM*IN_DIM;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic w_valid = 1'b0;
  logic pix_valid = 1'b0;
  logic [$clog2(K+1)-1:0] stride = '0;
  logic [PB-1:0] w_data = '0;
  logic [PB-1:0] pix_data = '0;
  logic [$clog2(OM*OM)-1:0] rd_addr = '0;
`ifdef SATURATE_OUT_EN
  logic [PB-1:0] rd_data;
`else
  logic [ACC-1:0] rd_data;
`endif
  logic [$clog2(OM+1)-1:0] out_dim;
  logic w_ready, pix_ready, busy, done, cfg_err;

  int n_chk = 0;
  int n_err = 0;
  int wv[NW];
  int pv[NP];
  int last_s = 0;

  deconv2d_mc #(
    .IN_DIM(IN_DIM), .K(K), .C_IN(C_IN), .PIXEL_BITS(PB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stride(stride),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_dim(out_dim), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input int y, input int x,
                                   input int s);
    longint sum = 0;
    int od;
    if (s == 0) return 0;
    od = (IN_DIM-1)*s + K;
    if (y >= od || x >= od) return 0;
    for (int c = 0; c < C_IN; c++)
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++) begin
          int dy = y - ky;
          int dx = x - kx;
          if (dy >= 0 && dx >= 0 && dy % s == 0 && dx % s == 0 &&
              dy / s < IN_DIM && dx / s < IN_DIM)
            sum += longint'(pv[c*IN_DIM*IN_DIM + (dy/s)*IN_DIM + dx/s])
                 * longint'(wv[c*K*K + ky*K + kx]);
        end
`ifdef SATURATE_OUT_EN
    if (sum > 127) sum = 127;
    if (sum < -128) sum = -128;
`endif
    return sum;
  endfunction

  task automatic check_all(input string tag);
    for (int a = 0; a < (1 << $bits(rd_addr)); a++) begin
      rd_addr = a[$bits(rd_addr)-1:0];
      @(negedge clk);
      chk($sformatf("%s rd[%0d]", tag, a), $signed(rd_data),
          model(a / OM, a % OM, last_s));
    end
  endtask

  task automatic run_job(input int s, input int abort_at);
    int wi = 0;
    int pi = 0;
    int cyc = 0;
    int dn = 0;
    int extra = -1;
    bit aborted = 0;
    start = 1'b1;
    stride = s[$bits(stride)-1:0];
    @(negedge clk);
    start = 1'b0;
    stride = '0;
    while (cyc < 3000) begin
      if (done) dn++;
      if (dn > 0 && extra < 0) extra = 4;
      if (extra == 0) break;
      if (extra > 0) extra--;
      if (cyc == 12) begin
        chk("busy_mid", busy, 1);
        chk("rd_busy_zero", $signed(rd_data), 0);
      end
      if (cyc == abort_at) begin
        w_valid = 1'b0;
        pix_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
        break;
      end
      w_valid = (wi < NW) && ($urandom_range(0, 3) != 0);
      if (wi < NW) w_data = PB'(wv[wi]);
      if (w_valid && w_ready) wi++;
      pix_valid = (pi < NP) && ($urandom_range(0, 3) != 0);
      if (pi < NP) pix_data = PB'(pv[pi]);
      if (pix_valid && pix_ready) pi++;
      @(negedge clk);
      cyc++;
    end
    w_valid = 1'b0;
    pix_valid = 1'b0;
    if (aborted) begin
      last_s = 0;
      for (int i = 0; i < 30; i++) begin
        if (done) dn++;
        @(negedge clk);
      end
      chk("abort_no_done", dn, 0);
      chk("abort_busy", busy, 0);
      chk("abort_out_dim", out_dim, 0);
    end else begin
      last_s = s;
      chk("done_once", dn, 1);
      chk("out_dim", out_dim, (IN_DIM-1)*s + K);
      chk("idle_busy", busy, 0);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NW; i++) wv[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < NP; i++) pv[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_rd_data", $signed(rd_data), 0);
    chk("rst_out_dim", out_dim, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NW; i++) wv[i] = 1;
    for (int i = 0; i < NP; i++) pv[i] = (i < NP/C_IN) ? 1 : -1;
    run_job(1, -1);
    check_all("cancel");

    for (int j = 0; j < 5; j++) begin
      rand_data();
      run_job(int'($urandom_range(1, K)), -1);
      check_all($sformatf("rand%0d", j));
    end

    for (int i = 0; i < NW; i++) wv[i] = 127;
    for (int i = 0; i < NP; i++) pv[i] = 127;
    run_job(1, -1);
    check_all("max_pos");

    for (int i = 0; i < NW; i++) wv[i] = -128;
    for (int i = 0; i < NP; i++) pv[i] = (i % 2 == 0) ? -128 : 127;
    run_job(2, -1);
    check_all("max_neg");

    start = 1'b1;
    stride = '0;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    @(negedge clk);
    chk("cfg_err_clear", cfg_err, 0);
    chk("cfg_err_out_dim", out_dim, 2*(IN_DIM-1) + K);
    check_all("after_cfg_err");

    rand_data();
    run_job(3, 40);
    check_all("after_abort");
    run_job(3, -1);
    check_all("rerun");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
